mux2_arbiter: RTL and testbench



---
 rtl/mux2_arbiter.sv | 82 ++++++++
 tb/tb_mux2_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// Two-source valid/ready arbiter feeding a one-entry registered output that also drives the shared 2:1 mux select.
// Define MUX2_ARB_RR_EN for round-robin arbitration; when it is undefined, source A has fixed priority.
module mux2_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             sel
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state, state_nxt;
   logic   load;
   logic   grant_a, grant_b;
   logic   prio;

   // Readies are gated by rst_n so that neither source sees a transfer while reset is held.
   assign load    = rst_n && ((state == EMPTY) || out_ready);
   assign a_ready = grant_a;
   assign b_ready = grant_b;

   always_comb begin
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      state_nxt = state;
      if (load) begin
         if (a_valid && (!b_valid || !prio))
            grant_a = 1'b1;
         else if (b_valid)
            grant_b = 1'b1;
      end
      if (grant_a || grant_b)
         state_nxt = FULL;
      else if ((state == FULL) && out_ready)
         state_nxt = EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= EMPTY;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         sel      <= 1'b0;
      end else if (grant_a || grant_b) begin
         out_data <= grant_b ? b_data : a_data;
         sel      <= grant_b;
      end
   end

`ifdef MUX2_ARB_RR_EN
   // The priority pointer moves to the source that lost this grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         prio <= 1'b0;
      else if (grant_a || grant_b)
         prio <= grant_a;
   end
`else
   assign prio = 1'b0;
`endif

   assign out_valid = (state == FULL);

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: a reference model predicts readies and queues each granted word for checking at the output.
module tb_mux2_arbiter;
   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
   logic [W-1:0] a_data = '0, b_data = '0;
   logic         a_ready, b_ready, out_valid, sel;
   logic [W-1:0] out_data;

   mux2_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .sel(sel)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         sel;
      logic [W-1:0] data;
   } word_t;

   int    n_tests = 0;
   int    n_fail = 0;
   word_t sb[$];
   word_t last = '0;
   logic  m_full = 1'b0;
   logic  m_prio = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model, evaluated between edges while inputs are stable.
   always @(negedge clk) begin
      logic ld, ga, gb;
      word_t w;
      if (!rst_n) begin
         sb.delete();
         m_full = 1'b0;
         m_prio = 1'b0;
         last   = '0;
         check("rst_a_ready", {31'd0, a_ready}, 32'd0);
         check("rst_b_ready", {31'd0, b_ready}, 32'd0);
         check("rst_out_valid", {31'd0, out_valid}, 32'd0);
         check("rst_out_data", {24'd0, out_data}, 32'd0);
         check("rst_sel", {31'd0, sel}, 32'd0);
      end else begin
         check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
         w = (m_full && sb.size() > 0) ? sb[0] : last;
         check("out_data", {24'd0, out_data}, {24'd0, w.data});
         check("sel", {31'd0, sel}, {31'd0, w.sel});
         ld = !m_full || out_ready;
         ga = ld && a_valid && (!b_valid || !m_prio);
         gb = ld && b_valid && !ga;
         check("a_ready", {31'd0, a_ready}, {31'd0, ga});
         check("b_ready", {31'd0, b_ready}, {31'd0, gb});
         if (ld && m_full && sb.size() > 0) begin
            last   = sb.pop_front();
            m_full = 1'b0;
         end
         if (ga || gb) begin
            sb.push_back({gb, gb ? b_data : a_data});
            m_full = 1'b1;
`ifdef MUX2_ARB_RR_EN
            m_prio = ga;
`endif
         end
      end
   end

   task automatic step(input logic av, input logic [W-1:0] ad,
                       input logic bv, input logic [W-1:0] bd, input logic ordy);
      @(posedge clk);
      #1;
      a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
   endtask

   initial begin
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) step(0, 8'h00, 0, 8'h00, 1);

      // Single A word, then drain.
      step(1, 8'h3C, 0, 8'h00, 1);
      repeat (2) step(0, 8'h00, 0, 8'h00, 1);

      // Continuous contention.
      repeat (8) step(1, 8'hAA, 1, 8'h55, 1);
      repeat (2) step(0, 8'h00, 0, 8'h00, 1);

      // Backpressure with A waiting behind a held B word.
      step(0, 8'h00, 1, 8'h11, 1);
      repeat (4) step(1, 8'h22, 0, 8'h00, 0);
      step(1, 8'h22, 0, 8'h00, 1);
      repeat (2) step(0, 8'h00, 0, 8'h00, 1);

      // Asynchronous reset while holding a word.
      step(1, 8'h77, 0, 8'h00, 1);
      step(0, 8'h00, 0, 8'h00, 0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("async_out_valid", {31'd0, out_valid}, 32'd0);
      check("async_out_data", {24'd0, out_data}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;

      // After reset prio is 0: contention must go to A first.
      step(1, 8'h5A, 1, 8'hA5, 1);
      repeat (2) step(0, 8'h00, 0, 8'h00, 1);

      // A then B single requests.
      step(1, 8'h01, 0, 8'h00, 1);
      step(0, 8'h00, 1, 8'h02, 1);
      repeat (2) step(0, 8'h00, 0, 8'h00, 1);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 3) != 0));
      repeat (3) step(0, 8'h00, 0, 8'h00, 1);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
